// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus controller: FSM states and command/address layout.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CA,
        ST_LAT,
        ST_WRITE,
        ST_READ,
        ST_CS_HOLD,
        ST_RECOVER
    } state_t;

    localparam int CA_RW    = 47;
    localparam int CA_AS    = 46;
    localparam int CA_BURST = 45;
    localparam int CA_BYTES = 6;

    // Memory space, linear burst; the word address is split around the reserved CA[15:3] field.
    function automatic logic [47:0] build_ca(input logic rd, input logic [31:0] adr);
        logic [47:0] ca;
        ca           = '0;
        ca[CA_RW]    = rd;
        ca[CA_AS]    = 1'b0;
        ca[CA_BURST] = 1'b1;
        ca[44:16]    = adr[31:3];
        ca[2:0]      = adr[2:0];
        return ca;
    endfunction

endpackage

// File: rtl/hyperbus_rd_capture.sv
// Read data capture: one DQ byte per RWDS transition, two bytes form a word.
// Latency: valid/dat_o one cycle after the second byte. No backpressure; waits indefinitely for RWDS.
// Cleared on READ entry so a stale RWDS level from latency is not mistaken for a strobe.
module hyperbus_rd_capture #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  hbus_clk,
    input  logic                  hbus_rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  rwds_i,
    input  logic [7:0]            dq_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  valid
);

    logic       rwds_prev;
    logic       phase;
    logic [7:0] hi_q;

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            rwds_prev <= 1'b0;
            phase     <= 1'b0;
            hi_q      <= 8'h00;
            dat_o     <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr) begin
                rwds_prev <= 1'b0;
                phase     <= 1'b0;
            end else if (en) begin
                rwds_prev <= rwds_i;
                if (rwds_i != rwds_prev) begin
                    if (!phase) begin
                        hi_q  <= dq_i;
                        phase <= 1'b1;
                    end else begin
                        dat_o <= DATA_WIDTH'({hi_q, dq_i});
                        valid <= 1'b1;
                        phase <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hyperbus_ctrl.sv
// HyperBus memory controller: native word requests -> CS#/CK/DQ/RWDS burst transactions.
// Latency: CS setup + 6 CA + latency + data + CS hold + recovery; data byte per hbus_clk cycle.
// Backpressure: busy blocks new requests; ready paces write words; `HYPERBUS_VAR_LATENCY_EN` samples RWDS for 1x/2x latency.
module hyperbus_ctrl
    import hyperbus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 16,
    parameter int BURST_WORDS = 2,
    parameter int LATENCY     = 6,
    parameter int RECOVERY    = 4
) (
    input  logic                  hbus_clk,
    input  logic                  hbus_rst,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  rrq,
    input  logic                  wrq,
    output logic                  ready,
    output logic                  valid,
    output logic                  busy,
    output logic                  hb_cs_n,
    output logic                  hb_ck,
    output logic [7:0]            hb_dq_o,
    output logic                  hb_dq_oe,
    input  logic [7:0]            hb_dq_i,
    output logic                  hb_rwds_o,
    output logic                  hb_rwds_oe,
    input  logic                  hb_rwds_i
);

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  wcnt;
    logic [47:0] ca_q;
    logic        is_rd;
    logic        rearm;
    logic        wr_hi;
    logic [7:0]  dq_q;
    logic        lat2x;
    logic [7:0]  lat_last;
    logic        rd_clr;
    logic        rd_en;

`ifndef HYPERBUS_VAR_LATENCY_EN
    assign lat2x = 1'b1;
`endif

    assign lat_last  = lat2x ? 8'(4*LATENCY-1) : 8'(2*LATENCY-1);
    assign rd_clr    = (state == ST_LAT) && (cnt == lat_last);
    assign rd_en     = (state == ST_READ);
    assign hb_rwds_o = 1'b0;
    // High byte goes straight from dat_i during the ready cycle; low byte is held for the next.
    assign hb_dq_o   = wr_hi ? dat_i[DATA_WIDTH-1 -: 8] : dq_q;

    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            wcnt       <= 8'd0;
            ca_q       <= '0;
            is_rd      <= 1'b0;
            rearm      <= 1'b1;
            wr_hi      <= 1'b0;
            dq_q       <= 8'h00;
            hb_cs_n    <= 1'b1;
            hb_ck      <= 1'b0;
            hb_dq_oe   <= 1'b0;
            hb_rwds_oe <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
`ifdef HYPERBUS_VAR_LATENCY_EN
            lat2x      <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
            if (!rrq && !wrq) rearm <= 1'b1;
            case (state)
                ST_IDLE: if ((rrq || wrq) && rearm) begin
                    rearm   <= 1'b0;
                    is_rd   <= rrq;
                    ca_q    <= build_ca(rrq, 32'(adr_i));
                    busy    <= 1'b1;
                    hb_cs_n <= 1'b0;
                    state   <= ST_CS_SETUP;
                end
                ST_CS_SETUP: begin
                    state    <= ST_CA;
                    cnt      <= 8'd0;
                    hb_ck    <= 1'b1;
                    hb_dq_oe <= 1'b1;
                    dq_q     <= ca_q[47:40];
                    ca_q     <= ca_q << 8;
                end
                ST_CA: begin
                    hb_ck <= ~hb_ck;
`ifdef HYPERBUS_VAR_LATENCY_EN
                    if (cnt == 8'd0) lat2x <= hb_rwds_i;
`endif
                    if (cnt == 8'(CA_BYTES-1)) begin
                        state    <= ST_LAT;
                        cnt      <= 8'd0;
                        hb_dq_oe <= 1'b0;
                        dq_q     <= 8'h00;
                    end else begin
                        cnt  <= cnt + 8'd1;
                        dq_q <= ca_q[47:40];
                        ca_q <= ca_q << 8;
                    end
                end
                ST_LAT: begin
                    hb_ck <= ~hb_ck;
                    if (cnt == lat_last) begin
                        cnt  <= 8'd0;
                        wcnt <= 8'd0;
                        if (is_rd) begin
                            state <= ST_READ;
                        end else begin
                            state      <= ST_WRITE;
                            hb_dq_oe   <= 1'b1;
                            hb_rwds_oe <= 1'b1;
                            wr_hi      <= 1'b1;
                            ready      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (wr_hi) begin
                        hb_ck <= ~hb_ck;
                        wr_hi <= 1'b0;
                        dq_q  <= dat_i[7:0];
                    end else if (wcnt == 8'(BURST_WORDS-1)) begin
                        state      <= ST_CS_HOLD;
                        hb_ck      <= 1'b0;
                        hb_dq_oe   <= 1'b0;
                        hb_rwds_oe <= 1'b0;
                        dq_q       <= 8'h00;
                    end else begin
                        hb_ck <= ~hb_ck;
                        wcnt  <= wcnt + 8'd1;
                        wr_hi <= 1'b1;
                        ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (valid && wcnt == 8'(BURST_WORDS-1)) begin
                        state <= ST_CS_HOLD;
                        hb_ck <= 1'b0;
                    end else begin
                        hb_ck <= ~hb_ck;
                        if (valid) wcnt <= wcnt + 8'd1;
                    end
                end
                ST_CS_HOLD: begin
                    state   <= ST_RECOVER;
                    hb_cs_n <= 1'b1;
                    cnt     <= 8'd0;
                end
                ST_RECOVER: begin
                    if (cnt == 8'(RECOVERY-1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    hyperbus_rd_capture #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_capture (
        .hbus_clk(hbus_clk),
        .hbus_rst(hbus_rst),
        .clr     (rd_clr),
        .en      (rd_en),
        .rwds_i  (hb_rwds_i),
        .dq_i    (hb_dq_i),
        .dat_o   (dat_o),
        .valid   (valid)
    );

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Directed bench for hyperbus_ctrl; acts as the HyperBus device for reads.
module tb_hyperbus_ctrl;

`ifdef HYPERBUS_VAR_LATENCY_EN
    localparam int LAT_LO = 12;
`else
    localparam int LAT_LO = 24;
`endif
    localparam int LAT_HI = 24;

    logic        hbus_clk = 1'b0;
    logic        hbus_rst = 1'b1;
    logic [31:0] adr_i = '0;
    logic [15:0] dat_i = '0;
    logic [15:0] dat_o;
    logic        rrq = 1'b0, wrq = 1'b0;
    logic        ready, valid, busy;
    logic        hb_cs_n, hb_ck, hb_dq_oe, hb_rwds_o, hb_rwds_oe;
    logic [7:0]  hb_dq_o;
    logic [7:0]  hb_dq_i = '0;
    logic        hb_rwds_i = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ca_b [6];
    logic [7:0]  wr_b [4];
    logic [15:0] rd_w [2];
    int          n_ca, n_wr, n_lat, n_hold, n_rec, n_rdy, n_val;
    bit          tmo, ck_ca0;

    always #5 hbus_clk = ~hbus_clk;

    hyperbus_ctrl dut (
        .hbus_clk  (hbus_clk),
        .hbus_rst  (hbus_rst),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .rrq       (rrq),
        .wrq       (wrq),
        .ready     (ready),
        .valid     (valid),
        .busy      (busy),
        .hb_cs_n   (hb_cs_n),
        .hb_ck     (hb_ck),
        .hb_dq_o   (hb_dq_o),
        .hb_dq_oe  (hb_dq_oe),
        .hb_dq_i   (hb_dq_i),
        .hb_rwds_o (hb_rwds_o),
        .hb_rwds_oe(hb_rwds_oe),
        .hb_rwds_i (hb_rwds_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] ca_word();
        return {ca_b[0], ca_b[1], ca_b[2], ca_b[3], ca_b[4], ca_b[5]};
    endfunction

    // Observes one transaction until busy falls; plays the device for reads.
    task automatic run_txn(input bit rd, input bit drop, input int rd_lat);
        bit seen, adv;
        int step;
        n_ca = 0; n_wr = 0; n_lat = 0; n_hold = 0; n_rec = 0; n_rdy = 0; n_val = 0;
        tmo = 1'b1; ck_ca0 = 1'b0; seen = 1'b0; adv = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge hbus_clk);
            if (busy) begin
                if (!seen && drop) begin rrq = 1'b0; wrq = 1'b0; end
                seen = 1'b1;
            end else if (seen) begin
                tmo = 1'b0;
                break;
            end
            if (!hb_cs_n && hb_dq_oe) begin
                if (n_ca < 6) begin
                    if (n_ca == 0) ck_ca0 = hb_ck;
                    ca_b[n_ca] = hb_dq_o;
                    n_ca++;
                end else if (n_wr < 4) begin
                    wr_b[n_wr] = hb_dq_o;
                    n_wr++;
                end
            end else if (!hb_cs_n && n_ca == 6) begin
                if (n_wr == 0) begin
                    n_lat++;
                    if (rd && n_lat > rd_lat) begin
                        step = n_lat - rd_lat - 1;
                        case (step)
                            0:       {hb_rwds_i, hb_dq_i} = 9'h111;
                            1:       {hb_rwds_i, hb_dq_i} = 9'h022;
                            2:       {hb_rwds_i, hb_dq_i} = 9'h0EE;
                            3:       {hb_rwds_i, hb_dq_i} = 9'h133;
                            4:       {hb_rwds_i, hb_dq_i} = 9'h044;
                            default: {hb_rwds_i, hb_dq_i} = 9'h000;
                        endcase
                    end
                end else begin
                    n_hold++;
                end
            end
            if (hb_cs_n && busy && n_ca == 6) n_rec++;
            if (ready) begin n_rdy++; adv = 1'b1; end
            if (valid) begin
                if (n_val < 2) rd_w[n_val] = dat_o;
                n_val++;
            end
            @(posedge hbus_clk);
            #1;
            if (adv) begin adv = 1'b0; dat_i = 16'h5A5A; end
        end
    endtask

    task automatic idle_watch(input int cycles, output int cs_low, output int rdy);
        cs_low = 0; rdy = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge hbus_clk);
            if (!hb_cs_n) cs_low++;
            if (ready) rdy++;
        end
    endtask

    initial begin
        int  cs_low, rdy;
        bit  got;

        // Reset state
        repeat (3) @(negedge hbus_clk);
        chk("rst_cs_n", hb_cs_n, 1);
        chk("rst_ck", hb_ck, 0);
        chk("rst_oe", {hb_dq_oe, hb_rwds_oe}, 0);
        chk("rst_dq", hb_dq_o, 0);
        chk("rst_flags", {busy, ready, valid}, 0);
        chk("rst_dat_o", dat_o, 0);
        @(posedge hbus_clk); #1 hbus_rst = 1'b0;
        repeat (2) @(posedge hbus_clk);
        #1;

        // Write burst, 2x latency
        adr_i = 32'h0000_1234; dat_i = 16'hA5A5; hb_rwds_i = 1'b1; wrq = 1'b1;
        run_txn(1'b0, 1'b1, 0);
        chk("wr_timeout", tmo, 0);
        chk("wr_ca", ca_word(), 48'h2000_0246_0004);
        chk("wr_ck_first_ca", ck_ca0, 1);
        chk("wr_latency", n_lat, 24);
        chk("wr_bytes", {wr_b[0], wr_b[1], wr_b[2], wr_b[3]}, 32'hA5A5_5A5A);
        chk("wr_ready_pulses", n_rdy, 2);
        chk("wr_cs_hold", n_hold, 1);
        chk("wr_recover", n_rec, 4);

        // Read burst, device strobes with one stalled cycle
        @(posedge hbus_clk); #1;
        adr_i = 32'h0000_0010; hb_rwds_i = 1'b0; rrq = 1'b1;
        run_txn(1'b1, 1'b1, LAT_LO);
        chk("rd_timeout", tmo, 0);
        chk("rd_ca", ca_word(), 48'hA000_0002_0000);
        chk("rd_valid_cnt", n_val, 2);
        chk("rd_word0", rd_w[0], 16'h1122);
        chk("rd_word1", rd_w[1], 16'h3344);
        chk("rd_recover", n_rec, 4);
        chk("rd_busy_end", busy, 0);

        // Both requests: read wins, write waits for rearm
        @(posedge hbus_clk); #1;
        adr_i = 32'h0000_0008; hb_rwds_i = 1'b0; rrq = 1'b1; wrq = 1'b1;
        run_txn(1'b1, 1'b0, LAT_LO);
        chk("both_timeout", tmo, 0);
        chk("both_ca", ca_word(), 48'hA000_0001_0000);
        chk("both_valid_cnt", n_val, 2);
        @(posedge hbus_clk); #1 rrq = 1'b0;
        idle_watch(20, cs_low, rdy);
        chk("norearm_cs_low", cs_low, 0);
        @(posedge hbus_clk); #1 wrq = 1'b0;
        @(posedge hbus_clk); #1;
        adr_i = 32'h0000_1234; dat_i = 16'hA5A5; wrq = 1'b1;
        run_txn(1'b0, 1'b1, 0);
        chk("rearm_wr_ca", ca_word(), 48'h2000_0246_0004);
        chk("rearm_wr_ready", n_rdy, 2);

        // Latency selection by RWDS during CA
        @(posedge hbus_clk); #1;
        dat_i = 16'hA5A5; hb_rwds_i = 1'b0; wrq = 1'b1;
        run_txn(1'b0, 1'b1, 0);
        chk("lat_rwds0", n_lat, LAT_LO);
        @(posedge hbus_clk); #1;
        dat_i = 16'hA5A5; hb_rwds_i = 1'b1; wrq = 1'b1;
        run_txn(1'b0, 1'b1, 0);
        chk("lat_rwds1", n_lat, LAT_HI);

        // Read request held high: exactly one transaction
        @(posedge hbus_clk); #1;
        adr_i = 32'h0000_0010; hb_rwds_i = 1'b0; rrq = 1'b1;
        run_txn(1'b1, 1'b0, LAT_LO);
        chk("held_timeout", tmo, 0);
        chk("held_valid_cnt", n_val, 2);
        idle_watch(30, cs_low, rdy);
        chk("held_no_retrigger", cs_low, 0);
        @(posedge hbus_clk); #1 rrq = 1'b0;
        @(posedge hbus_clk); #1;

        // Reset during WRITE
        adr_i = 32'h0000_0040; dat_i = 16'hA5A5; hb_rwds_i = 1'b1; wrq = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge hbus_clk);
            if (busy) wrq = 1'b0;
            if (ready) got = 1'b1;
        end
        chk("rst_reach_write", got, 1);
        #2 hbus_rst = 1'b1;
        #1;
        chk("rst_async_cs_n", hb_cs_n, 1);
        chk("rst_async_oe", {hb_dq_oe, hb_rwds_oe}, 0);
        chk("rst_async_busy", {busy, ready}, 0);
        @(posedge hbus_clk); @(posedge hbus_clk); #1 hbus_rst = 1'b0;
        idle_watch(20, cs_low, rdy);
        chk("rst_no_ready", rdy, 0);
        chk("rst_no_cs", cs_low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
